// File: rtl/rvj1_dec_q.sv
// Queued RV32I decoder: decodes OP-IMM/OP/LUI/AUIPC/LOAD/STORE into ALU/LSU control
// entries and buffers them in a small FIFO with valid/ready handshakes on both sides.

package rvj1_dec_q_pkg;

  typedef enum logic [3:0] {
    ALU_OP_ADD, ALU_OP_SUB, ALU_OP_SLL, ALU_OP_SLT, ALU_OP_SLTU,
    ALU_OP_XOR, ALU_OP_SRL, ALU_OP_SRA, ALU_OP_OR, ALU_OP_AND
  } alu_op_e;

  typedef enum logic [3:0] {
    LSU_NO_CMD, LSU_LOAD_BYTE, LSU_LOAD_HALF, LSU_LOAD_WORD, LSU_LOAD_BYTE_U,
    LSU_LOAD_HALF_U, LSU_STORE_BYTE, LSU_STORE_HALF, LSU_STORE_WORD
  } lsu_ctrl_e;

endpackage

module rvj1_dec_q
  import rvj1_dec_q_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RALEN = 5,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [XLEN-1:0]  ifu_instr_i,
  input  logic             ifu_valid_i,
  output logic             ifu_ready_o,
  input  logic             flush_i,
  output logic             dec_valid_o,
  input  logic             dec_ready_i,
  output logic [RALEN-1:0] rf_addr_a_o,
  output logic [RALEN-1:0] rf_addr_b_o,
  output alu_op_e          alu_sel_o,
  output logic             rpa_or_pc_o,
  output logic             rpb_or_imm_o,
  output logic             alu_write_rf_o,
  output logic [RALEN-1:0] alu_regdest_o,
  output logic [XLEN-1:0]  immediate_o,
  output logic             lsu_ctrl_valid_o,
  output lsu_ctrl_e        lsu_ctrl_o,
  output logic [RALEN-1:0] lsu_regdest_o,
  output logic             illegal_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;
  localparam logic [6:0] OpcLoad  = 7'b0000011;
  localparam logic [6:0] OpcStore = 7'b0100011;

  typedef struct packed {
    logic [RALEN-1:0] addr_a;
    logic [RALEN-1:0] addr_b;
    alu_op_e          alu_sel;
    logic             rpa_or_pc;
    logic             rpb_or_imm;
    logic             alu_write_rf;
    logic [RALEN-1:0] alu_regdest;
    logic [XLEN-1:0]  immediate;
    logic             lsu_valid;
    lsu_ctrl_e        lsu_ctrl;
    logic [RALEN-1:0] lsu_regdest;
    logic             illegal;
  } entry_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] imm_i, imm_s, imm_u, imm_sh;

  assign opcode = ifu_instr_i[6:0];
  assign funct3 = ifu_instr_i[14:12];
  assign funct7 = ifu_instr_i[31:25];
  assign rs1    = ifu_instr_i[19:15];
  assign rs2    = ifu_instr_i[24:20];
  assign rd     = ifu_instr_i[11:7];
  assign imm_i  = {{(XLEN-12){ifu_instr_i[31]}}, ifu_instr_i[31:20]};
  assign imm_s  = {{(XLEN-12){ifu_instr_i[31]}}, ifu_instr_i[31:25], ifu_instr_i[11:7]};
  assign imm_u  = {ifu_instr_i[XLEN-1:12], 12'b0};
  assign imm_sh = {{(XLEN-5){1'b0}}, ifu_instr_i[24:20]};

  entry_t entry_d;
  logic   ill;

  // Decode the incoming instruction into a queue entry; illegal ones collapse to a bare flag.
  always_comb begin
    entry_d = '0;
    ill     = 1'b0;
    case (opcode)
      OpcOpImm: begin
        entry_d.addr_a       = rs1;
        entry_d.rpb_or_imm   = 1'b1;
        entry_d.alu_write_rf = 1'b1;
        entry_d.alu_regdest  = rd;
        entry_d.immediate    = imm_i;
        case (funct3)
          3'b000: entry_d.alu_sel = ALU_OP_ADD;
          3'b010: entry_d.alu_sel = ALU_OP_SLT;
          3'b011: entry_d.alu_sel = ALU_OP_SLTU;
          3'b100: entry_d.alu_sel = ALU_OP_XOR;
          3'b110: entry_d.alu_sel = ALU_OP_OR;
          3'b111: entry_d.alu_sel = ALU_OP_AND;
          3'b001: begin
            entry_d.alu_sel   = ALU_OP_SLL;
            entry_d.immediate = imm_sh;
            ill               = (funct7 != 7'b0000000);
          end
          3'b101: begin
            entry_d.immediate = imm_sh;
            if (funct7 == 7'b0000000)      entry_d.alu_sel = ALU_OP_SRL;
            else if (funct7 == 7'b0100000) entry_d.alu_sel = ALU_OP_SRA;
            else                           ill = 1'b1;
          end
        endcase
      end
      OpcOp: begin
        entry_d.addr_a       = rs1;
        entry_d.addr_b       = rs2;
        entry_d.alu_write_rf = 1'b1;
        entry_d.alu_regdest  = rd;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000: entry_d.alu_sel = ALU_OP_ADD;
            3'b001: entry_d.alu_sel = ALU_OP_SLL;
            3'b010: entry_d.alu_sel = ALU_OP_SLT;
            3'b011: entry_d.alu_sel = ALU_OP_SLTU;
            3'b100: entry_d.alu_sel = ALU_OP_XOR;
            3'b101: entry_d.alu_sel = ALU_OP_SRL;
            3'b110: entry_d.alu_sel = ALU_OP_OR;
            3'b111: entry_d.alu_sel = ALU_OP_AND;
          endcase
        end else if (funct7 == 7'b0100000) begin
          case (funct3)
            3'b000:  entry_d.alu_sel = ALU_OP_SUB;
            3'b101:  entry_d.alu_sel = ALU_OP_SRA;
            default: ill = 1'b1;
          endcase
        end else begin
          ill = 1'b1;
        end
      end
      OpcLui, OpcAuipc: begin
        entry_d.rpa_or_pc    = (opcode == OpcAuipc);
        entry_d.rpb_or_imm   = 1'b1;
        entry_d.alu_write_rf = 1'b1;
        entry_d.alu_regdest  = rd;
        entry_d.immediate    = imm_u;
      end
      OpcLoad: begin
        entry_d.addr_a      = rs1;
        entry_d.rpb_or_imm  = 1'b1;
        entry_d.immediate   = imm_i;
        entry_d.lsu_valid   = 1'b1;
        entry_d.lsu_regdest = rd;
        case (funct3)
          3'b000:  entry_d.lsu_ctrl = LSU_LOAD_BYTE;
          3'b001:  entry_d.lsu_ctrl = LSU_LOAD_HALF;
          3'b010:  entry_d.lsu_ctrl = LSU_LOAD_WORD;
          3'b100:  entry_d.lsu_ctrl = LSU_LOAD_BYTE_U;
          3'b101:  entry_d.lsu_ctrl = LSU_LOAD_HALF_U;
          default: ill = 1'b1;
        endcase
      end
      OpcStore: begin
        entry_d.addr_a     = rs1;
        entry_d.addr_b     = rs2;
        entry_d.rpb_or_imm = 1'b1;
        entry_d.immediate  = imm_s;
        entry_d.lsu_valid  = 1'b1;
        case (funct3)
          3'b000:  entry_d.lsu_ctrl = LSU_STORE_BYTE;
          3'b001:  entry_d.lsu_ctrl = LSU_STORE_HALF;
          3'b010:  entry_d.lsu_ctrl = LSU_STORE_WORD;
          default: ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      entry_d         = '0;
      entry_d.illegal = 1'b1;
    end
  end

  entry_t          mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;

  // Ready/valid come straight from the occupancy register, never from dec_ready_i.
  assign ifu_ready_o = (count_q != CntW'(DEPTH));
  assign dec_valid_o = (count_q != '0);
  assign push        = ifu_valid_i & ifu_ready_o & ~flush_i;
  assign pop         = dec_valid_o & dec_ready_i & ~flush_i;

  // Next pointer/occupancy; flush wins over any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Queue control state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful below count_q, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= entry_d;
  end

  entry_t head;
  assign head = dec_valid_o ? mem_q[rd_ptr_q] : '0;

  assign rf_addr_a_o      = head.addr_a;
  assign rf_addr_b_o      = head.addr_b;
  assign alu_sel_o        = head.alu_sel;
  assign rpa_or_pc_o      = head.rpa_or_pc;
  assign rpb_or_imm_o     = head.rpb_or_imm;
  assign alu_write_rf_o   = head.alu_write_rf;
  assign alu_regdest_o    = head.alu_regdest;
  assign immediate_o      = head.immediate;
  assign lsu_ctrl_valid_o = head.lsu_valid;
  assign lsu_ctrl_o       = head.lsu_ctrl;
  assign lsu_regdest_o    = head.lsu_regdest;
  assign illegal_o        = head.illegal;

endmodule

// File: tb/tb_rvj1_dec_q.sv
// Directed-vector bench for rvj1_dec_q: decode table, fill/drain, random handshake, flush, reset.

module tb_rvj1_dec_q;
  import rvj1_dec_q_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int NV = 17;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] ifu_instr;
  logic        ifu_valid, ifu_ready, flush, dec_valid, dec_ready;
  logic [4:0]  rf_a, rf_b, alu_rd, lsu_rd;
  alu_op_e     alu_sel;
  logic        rpa_pc, rpb_imm, alu_wr, lsu_v, illegal;
  logic [31:0] imm;
  lsu_ctrl_e   lsu_ctrl;

  always #5 clk = ~clk;

  rvj1_dec_q #(.XLEN(32), .RALEN(5), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rstn_i(rstn), .ifu_instr_i(ifu_instr), .ifu_valid_i(ifu_valid),
    .ifu_ready_o(ifu_ready), .flush_i(flush), .dec_valid_o(dec_valid), .dec_ready_i(dec_ready),
    .rf_addr_a_o(rf_a), .rf_addr_b_o(rf_b), .alu_sel_o(alu_sel), .rpa_or_pc_o(rpa_pc),
    .rpb_or_imm_o(rpb_imm), .alu_write_rf_o(alu_wr), .alu_regdest_o(alu_rd),
    .immediate_o(imm), .lsu_ctrl_valid_o(lsu_v), .lsu_ctrl_o(lsu_ctrl),
    .lsu_regdest_o(lsu_rd), .illegal_o(illegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  a, b;
    alu_op_e     alu;
    logic        pc, bi, wr;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        lv;
    lsu_ctrl_e   lc;
    logic [4:0]  ld;
    logic        ill;
  } vec_t;

  vec_t vt [NV];
  int   total = 0;
  int   bad = 0;
  int   q [$];

  logic [65:0] act;
  assign act = {dec_valid, rf_a, rf_b, alu_sel, rpa_pc, rpb_imm, alu_wr, alu_rd, imm,
                lsu_v, lsu_ctrl, lsu_rd, illegal};

  function automatic logic [65:0] expv(input vec_t v);
    return {1'b1, v.a, v.b, v.alu, v.pc, v.bi, v.wr, v.rd, v.imm, v.lv, v.lc, v.ld, v.ill};
  endfunction

  function automatic vec_t illv(input logic [31:0] i);
    vec_t v;
    v = '{i, 5'd0, 5'd0, ALU_OP_ADD, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, LSU_NO_CMD, 5'd0, 1'b1};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [65:0] e);
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, e);
    end
  endtask

  task automatic chkb(input string nm, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%b want=%b", nm, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // instr, a, b, alu, pc, bi, wr, rd, imm, lv, lc, ld, ill
    vt[0]  = '{32'h00500093, 5'd0, 5'd0, ALU_OP_ADD, 1'b0, 1'b1, 1'b1, 5'd1, 32'd5,
               1'b0, LSU_NO_CMD, 5'd0, 1'b0};
    vt[1]  = '{32'h40415193, 5'd2, 5'd0, ALU_OP_SRA, 1'b0, 1'b1, 1'b1, 5'd3, 32'h4,
               1'b0, LSU_NO_CMD, 5'd0, 1'b0};
    vt[2]  = illv(32'h40411193);
    vt[3]  = '{32'h407302B3, 5'd6, 5'd7, ALU_OP_SUB, 1'b0, 1'b0, 1'b1, 5'd5, 32'd0,
               1'b0, LSU_NO_CMD, 5'd0, 1'b0};
    vt[4]  = '{32'hFFC12203, 5'd2, 5'd0, ALU_OP_ADD, 1'b0, 1'b1, 1'b0, 5'd0, 32'hFFFF_FFFC,
               1'b1, LSU_LOAD_WORD, 5'd4, 1'b0};
    vt[5]  = '{32'h00712423, 5'd2, 5'd7, ALU_OP_ADD, 1'b0, 1'b1, 1'b0, 5'd0, 32'd8,
               1'b1, LSU_STORE_WORD, 5'd0, 1'b0};
    vt[6]  = '{32'h12345537, 5'd0, 5'd0, ALU_OP_ADD, 1'b0, 1'b1, 1'b1, 5'd10, 32'h1234_5000,
               1'b0, LSU_NO_CMD, 5'd0, 1'b0};
    vt[7]  = '{32'hFFFFF597, 5'd0, 5'd0, ALU_OP_ADD, 1'b1, 1'b1, 1'b1, 5'd11, 32'hFFFF_F000,
               1'b0, LSU_NO_CMD, 5'd0, 1'b0};
    vt[8]  = illv(32'h00000000);
    vt[9]  = illv(32'hFFFFFFFF);
    vt[10] = '{32'h7FF0C303, 5'd1, 5'd0, ALU_OP_ADD, 1'b0, 1'b1, 1'b0, 5'd0, 32'h7FF,
               1'b1, LSU_LOAD_BYTE_U, 5'd6, 1'b0};
    vt[11] = illv(32'h00013203);
    vt[12] = '{32'hFFF0B113, 5'd1, 5'd0, ALU_OP_SLTU, 1'b0, 1'b1, 1'b1, 5'd2, 32'hFFFF_FFFF,
               1'b0, LSU_NO_CMD, 5'd0, 1'b0};
    vt[13] = '{32'h00A4F433, 5'd9, 5'd10, ALU_OP_AND, 1'b0, 1'b0, 1'b1, 5'd8, 32'd0,
               1'b0, LSU_NO_CMD, 5'd0, 1'b0};
    vt[14] = illv(32'h40A49433);
    vt[15] = '{32'hFE519FA3, 5'd3, 5'd5, ALU_OP_ADD, 1'b0, 1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF,
               1'b1, LSU_STORE_HALF, 5'd0, 1'b0};
    vt[16] = '{32'h01F0D093, 5'd1, 5'd0, ALU_OP_SRL, 1'b0, 1'b1, 1'b1, 5'd1, 32'd31,
               1'b0, LSU_NO_CMD, 5'd0, 1'b0};

    rstn = 1'b0; ifu_instr = '0; ifu_valid = 1'b0; flush = 1'b0; dec_ready = 1'b0;
    step(); step();
    rstn = 1'b1;
    chk("reset_outputs", '0);
    chkb("reset_ready", ifu_ready, 1'b1);

    // Decode table: one push, check head, pop, check empty.
    for (int i = 0; i < NV; i++) begin
      ifu_instr = vt[i].instr; ifu_valid = 1'b1;
      step();
      ifu_valid = 1'b0;
      chk($sformatf("vec%0d_%h", i, vt[i].instr), expv(vt[i]));
      dec_ready = 1'b1;
      step();
      dec_ready = 1'b0;
      chk($sformatf("vec%0d_pop", i), '0);
    end

    // Fill to DEPTH with consumer stalled; one extra push must be refused.
    for (int k = 0; k < int'(DEPTH); k++) begin
      chkb($sformatf("fill_ready%0d", k), ifu_ready, 1'b1);
      ifu_instr = vt[k].instr; ifu_valid = 1'b1;
      step();
    end
    chkb("full_ready", ifu_ready, 1'b0);
    ifu_instr = vt[5].instr;
    step();
    ifu_valid = 1'b0;
    chkb("full_hold", ifu_ready, 1'b0);
    dec_ready = 1'b1;
    for (int k = 0; k < int'(DEPTH); k++) begin
      chk($sformatf("drain%0d", k), expv(vt[k]));
      step();
    end
    dec_ready = 1'b0;
    chk("drain_empty", '0);

    // Push+pop at occupancy 1 keeps one entry, now the newly pushed one.
    ifu_instr = vt[6].instr; ifu_valid = 1'b1;
    step();
    ifu_instr = vt[7].instr; dec_ready = 1'b1;
    step();
    ifu_valid = 1'b0;
    chk("pushpop_head", expv(vt[7]));
    step();
    dec_ready = 1'b0;
    chk("pushpop_empty", '0);

    // Random handshakes against a queue model.
    for (int c = 0; c < 400; c++) begin
      int  idx;
      logic v, r, pu, po;
      chkb("rnd_ready", ifu_ready, (q.size() != int'(DEPTH)));
      if (q.size() != 0) chk("rnd_head", expv(vt[q[0]]));
      else               chk("rnd_empty", '0);
      idx = $urandom_range(0, NV - 1);
      v   = ($urandom_range(0, 2) != 0);
      r   = ($urandom_range(0, 1) != 0);
      pu  = v && (q.size() != int'(DEPTH));
      po  = r && (q.size() != 0);
      ifu_instr = vt[idx].instr; ifu_valid = v; dec_ready = r;
      step();
      if (po) void'(q.pop_front());
      if (pu) q.push_back(idx);
    end
    ifu_valid = 1'b0; dec_ready = 1'b1;
    for (int c = 0; c < int'(DEPTH); c++) step();
    dec_ready = 1'b0;
    q.delete();
    chk("rnd_drained", '0);

    // Flush with two queued entries and a concurrent push and pop.
    for (int k = 0; k < 2; k++) begin
      ifu_instr = vt[k].instr; ifu_valid = 1'b1;
      step();
    end
    ifu_instr = vt[3].instr; flush = 1'b1; dec_ready = 1'b1;
    step();
    flush = 1'b0; ifu_valid = 1'b0;
    chk("flush_empty", '0);
    chkb("flush_ready", ifu_ready, 1'b1);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("flush_after%0d", c), '0);
    end
    dec_ready = 1'b0;

    // Reset in the middle of a drain; the push during reset must be dropped.
    for (int k = 3; k < 6; k++) begin
      ifu_instr = vt[k].instr; ifu_valid = 1'b1;
      step();
    end
    ifu_valid = 1'b0; dec_ready = 1'b1;
    step();
    chk("middrain_head", expv(vt[4]));
    rstn = 1'b0; ifu_valid = 1'b1; ifu_instr = vt[6].instr;
    step();
    rstn = 1'b1; ifu_valid = 1'b0; dec_ready = 1'b0;
    chk("rst_mid_outputs", '0);
    chkb("rst_mid_ready", ifu_ready, 1'b1);
    step();
    chk("rst_mid_after", '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
